// File: rtl/outfifo_reader.sv
// Read-side sequencer for the DAQ/trigger output FIFO: pops 48-bit words and serialises each
// into three 16-bit frames on a valid/ready link. OUTFIFO_RD_PARITY_EN adds the tx_par output.
module outfifo_reader #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             rdclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             fifo_empty,
    output logic             fifo_rden,
    input  logic [47:0]      fifo_dout,
    output logic [15:0]      tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_first,
    output logic             tx_last,
    output logic             tx_daq,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
`ifdef OUTFIFO_RD_PARITY_EN
    ,
    output logic             tx_par
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StWait,
        StSend,
        StDrop
    } state_e;

    localparam logic [1:0] WaitLast  = 2'(RD_LAT - 1);
    localparam logic [1:0] FrameLast = 2'd2;

    state_e            state_q, state_d;
    logic              drop_q, drop_d;
    logic [1:0]        wait_q, wait_d;
    logic [1:0]        frame_q, frame_d;
    logic [47:0]       word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              send;

    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
            wait_q  <= 2'd0;
            frame_q <= 2'd0;
            word_q  <= 48'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            wait_q  <= wait_d;
            frame_q <= frame_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mode (send/drop) is fixed at the word boundary that commits to the next pop.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        wait_d    = wait_q;
        frame_d   = frame_q;
        word_d    = word_q;
        fifo_rden = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && (en || flush)) begin
                    state_d = StPop;
                    drop_d  = flush;
                end
            end
            StPop: begin
                // Holding here while empty keeps the FIFO from ever being read when empty.
                if (!fifo_empty) begin
                    fifo_rden = 1'b1;
                    wait_d    = 2'd0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (wait_q == WaitLast) begin
                    word_d  = fifo_dout;
                    frame_d = 2'd0;
                    state_d = drop_q ? StDrop : StSend;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    if (frame_q == FrameLast) begin
                        if (!fifo_empty && en && !flush) begin
                            state_d = StPop;
                            drop_d  = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        frame_d = frame_q + 2'd1;
                    end
                end
            end
            StDrop: begin
                if (!fifo_empty && flush) begin
                    state_d = StPop;
                    drop_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, fifo_rden};
    end

    always_comb begin
        send     = (state_q == StSend);
        tx_valid = send;
        busy     = (state_q != StIdle);
        tx_first = send && (frame_q == 2'd0);
        tx_last  = send && (frame_q == FrameLast);
        tx_daq   = send && word_q[27];
        word_cnt = cnt_q;
        tx_data  = 16'd0;
        if (send) begin
            unique case (frame_q)
                2'd0:    tx_data = word_q[15:0];
                2'd1:    tx_data = word_q[31:16];
                default: tx_data = word_q[47:32];
            endcase
        end
    end

`ifdef OUTFIFO_RD_PARITY_EN
    // Odd parity across {tx_daq, tx_data, tx_par}.
    always_comb begin
        tx_par = send && !(^{tx_daq, tx_data});
    end
`endif

endmodule

// File: tb/tb_outfifo_reader.sv
// Randomised bench for outfifo_reader with a FIFO model and a word-level reference model,
// plus directed literal scenarios (reset, single word, burst, backpressure, flush, abort).
module tb_outfifo_reader;

    localparam int RdLat = 1;
    localparam int CntW  = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
        logic        daq;
        logic        par;
    } frame_t;

    logic            rdclk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            flush;
    logic            fifo_empty;
    logic            fifo_rden;
    logic [47:0]     fifo_dout;
    logic [15:0]     tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            tx_first;
    logic            tx_last;
    logic            tx_daq;
    logic            busy;
    logic [CntW-1:0] word_cnt;
`ifdef OUTFIFO_RD_PARITY_EN
    logic            tx_par;
`endif

    always #5 rdclk = ~rdclk;

    outfifo_reader #(
        .RD_LAT(RdLat),
        .CNT_W (CntW)
    ) u_dut (
        .rdclk     (rdclk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .fifo_empty(fifo_empty),
        .fifo_rden (fifo_rden),
        .fifo_dout (fifo_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_first  (tx_first),
        .tx_last   (tx_last),
        .tx_daq    (tx_daq),
        .busy      (busy),
        .word_cnt  (word_cnt)
`ifdef OUTFIFO_RD_PARITY_EN
        ,
        .tx_par    (tx_par)
`endif
    );

    int total = 0;
    int bad   = 0;

    // FIFO model
    logic [47:0] fifo_q[$];
    logic [47:0] pipe[0:2];
    logic        push_req;
    logic [47:0] push_word;

    // Word-level reference: active word, cycles since its pop, frame index, drop mode.
    bit              m_armed;
    bit              m_active;
    bit              m_drop;
    int              m_age;
    int              m_frame;
    logic [47:0]     m_word;
    logic [CntW-1:0] m_cnt;

    // Inputs as seen by the next clock edge
    logic        s_rst, s_en, s_flush, s_ready, s_empty, s_rden, s_push;
    logic [47:0] s_word;

    frame_t got_q[$];
    int     cnt_busy, cnt_rden, cnt_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    function automatic bit m_send();
        return m_active && (m_age == RdLat + 1) && !m_drop;
    endfunction

    task automatic step();
        logic [47:0] popped;
        if (!s_rst) begin
            m_armed  = 1'b1;
            m_active = 1'b0;
            m_drop   = 1'b0;
            m_age    = 0;
            m_frame  = 0;
            m_cnt    = '0;
        end else if (!m_active) begin
            if (!s_empty && (s_en || s_flush)) begin
                m_active = 1'b1;
                m_age    = 0;
                m_drop   = s_flush;
            end
        end else if (m_age == 0) begin
            if (!s_empty) begin
                if (fifo_q.size() > 0) m_word = fifo_q[0];
                m_cnt = m_cnt + CntW'(1);
                m_age = 1;
            end
        end else if (m_age <= RdLat) begin
            m_age++;
            m_frame = 0;
        end else if (m_drop) begin
            if (!s_empty && s_flush) m_age = 0;
            else m_active = 1'b0;
        end else if (s_ready) begin
            if (m_frame == 2) begin
                if (!s_empty && s_en && !s_flush) m_age = 0;
                else m_active = 1'b0;
            end else begin
                m_frame++;
            end
        end

        chk("no_read_when_empty", 64'(s_rden && s_empty), 64'(0));
        popped = rnd48();
        if (s_rden && fifo_q.size() > 0) popped = fifo_q.pop_front();
        pipe[2]   = pipe[1];
        pipe[1]   = pipe[0];
        pipe[0]   = popped;
        fifo_dout = pipe[RdLat-1];
        if (s_push) fifo_q.push_back(s_word);
        push_req   = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic compare();
        logic [15:0] e_data;
        logic        e_send, e_daq;
        if (!m_armed) return;
        e_send = m_send();
        e_data = e_send ? m_word[16*m_frame +: 16] : 16'd0;
        e_daq  = e_send && m_word[27];
        chk("rden",     64'(fifo_rden), 64'(m_active && m_age == 0 && !fifo_empty));
        chk("tx_valid", 64'(tx_valid),  64'(e_send));
        chk("tx_data",  64'(tx_data),   64'(e_data));
        chk("tx_first", 64'(tx_first),  64'(e_send && m_frame == 0));
        chk("tx_last",  64'(tx_last),   64'(e_send && m_frame == 2));
        chk("tx_daq",   64'(tx_daq),    64'(e_daq));
        chk("busy",     64'(busy),      64'(m_active));
        chk("word_cnt", 64'(word_cnt),  64'(m_cnt));
`ifdef OUTFIFO_RD_PARITY_EN
        chk("tx_par", 64'(tx_par), 64'(e_send && ($countones({e_daq, e_data}) % 2 == 0)));
`endif
    endtask

    task automatic cycle();
        frame_t f;
        s_rst   = rst_n;
        s_en    = en;
        s_flush = flush;
        s_ready = tx_ready;
        s_empty = fifo_empty;
        s_rden  = fifo_rden;
        s_push  = push_req;
        s_word  = push_word;
        if (tx_valid && tx_ready) begin
            f.data  = tx_data;
            f.first = tx_first;
            f.last  = tx_last;
            f.daq   = tx_daq;
`ifdef OUTFIFO_RD_PARITY_EN
            f.par   = tx_par;
`else
            f.par   = 1'b0;
`endif
            got_q.push_back(f);
        end
        if (busy) cnt_busy++;
        if (fifo_rden) cnt_rden++;
        if (tx_valid) cnt_valid++;
        @(posedge rdclk);
        #1;
        step();
        @(negedge rdclk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push(input logic [47:0] w);
        push_req  = 1'b1;
        push_word = w;
        cycle();
    endtask

    task automatic wait_mid_frame(input string name);
        int n;
        n = 0;
        while (!(m_send() && m_frame == 1) && n < 60) begin
            cycle();
            n++;
        end
        chk({name, "_reached_frame1"}, 64'(n < 60), 64'(1));
    endtask

    logic [47:0]     w3[4];
    logic            d3[4];
    logic [15:0]     e4[6];
    logic [CntW-1:0] base;

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        flush      = 1'b0;
        tx_ready   = 1'b1;
        push_req   = 1'b0;
        push_word  = '0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        m_armed    = 1'b0;
        m_active   = 1'b0;
        m_drop     = 1'b0;
        m_age      = 0;
        m_frame    = 0;
        m_word     = '0;
        m_cnt      = '0;
        for (int i = 0; i < 3; i++) pipe[i] = rnd48();

        // Reset held with a word waiting and en high
        cycle();
        push(48'h0123_4567_89AB);
        run(3);
        chk("t1_rden",     64'(fifo_rden), 64'(0));
        chk("t1_valid",    64'(tx_valid),  64'(0));
        chk("t1_word_cnt", 64'(word_cnt),  64'(0));
        chk("t1_busy",     64'(busy),      64'(0));

        // Single word
        rst_n = 1'b1;
        got_q.delete();
        run(12);
        chk("t2_frames", 64'(got_q.size()), 64'(3));
        if (got_q.size() >= 3) begin
            chk("t2_f0_data",  64'(got_q[0].data),  64'(16'h89AB));
            chk("t2_f0_first", 64'(got_q[0].first), 64'(1));
            chk("t2_f0_last",  64'(got_q[0].last),  64'(0));
            chk("t2_f1_data",  64'(got_q[1].data),  64'(16'h4567));
            chk("t2_f1_first", 64'(got_q[1].first), 64'(0));
            chk("t2_f2_data",  64'(got_q[2].data),  64'(16'h0123));
            chk("t2_f2_last",  64'(got_q[2].last),  64'(1));
            for (int i = 0; i < 3; i++) chk("t2_daq", 64'(got_q[i].daq), 64'(0));
        end
        chk("t2_word_cnt", 64'(word_cnt), 64'(1));
        chk("t2_busy",     64'(busy),     64'(0));
        chk("t2_model_cnt", 64'(m_cnt),   64'(1));

        // Four queued words, back to back
        w3[0] = 48'h1111_2222_3333;
        w3[1] = 48'h0000_0800_0000;
        w3[2] = 48'hFFFF_FFFF_FFFF;
        w3[3] = 48'hA5A5_5A5A_0F0F;
        d3[0] = 1'b0;
        d3[1] = 1'b1;
        d3[2] = 1'b1;
        d3[3] = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 4; i++) push(w3[i]);
        run(2);
        cnt_busy = 0;
        cnt_rden = 0;
        got_q.delete();
        en = 1'b1;
        run(30);
        chk("t3_busy_cycles", 64'(cnt_busy), 64'(20));
        chk("t3_rden_pulses", 64'(cnt_rden), 64'(4));
        chk("t3_frames", 64'(got_q.size()), 64'(12));
        if (got_q.size() >= 12) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 3; k++) begin
                    chk("t3_data", 64'(got_q[3*i+k].data), 64'(w3[i][16*k +: 16]));
                    chk("t3_daq",  64'(got_q[3*i+k].daq),  64'(d3[i]));
                end
            end
        end
        chk("t3_word_cnt", 64'(word_cnt), 64'(5));

        // Backpressure on frame 1 with a second word waiting
        e4[0] = 16'hBEEF;
        e4[1] = 16'h4567;
        e4[2] = 16'hCAFE;
        e4[3] = 16'h2468;
        e4[4] = 16'h9BDF;
        e4[5] = 16'h1357;
        en = 1'b0;
        push(48'hCAFE_4567_BEEF);
        push(48'h1357_9BDF_2468);
        got_q.delete();
        en = 1'b1;
        wait_mid_frame("t4");
        tx_ready = 1'b0;
        cnt_rden = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t4_hold_data",  64'(tx_data),  64'(16'h4567));
            chk("t4_hold_valid", 64'(tx_valid), 64'(1));
        end
        chk("t4_no_rden_stalled", 64'(cnt_rden), 64'(0));
        tx_ready = 1'b1;
        run(20);
        chk("t4_frames", 64'(got_q.size()), 64'(6));
        if (got_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("t4_data", 64'(got_q[i].data), 64'(e4[i]));
        end

        // Flush three words
        en = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd48());
        cnt_rden  = 0;
        cnt_valid = 0;
        base      = m_cnt;
        flush     = 1'b1;
        run(30);
        flush = 1'b0;
        chk("t5_rden_pulses", 64'(cnt_rden),  64'(3));
        chk("t5_valid_never", 64'(cnt_valid), 64'(0));
        chk("t5_word_cnt",    64'(word_cnt),  64'(base + CntW'(3)));

        // Reset during frame 1
        push(48'h0000_0001_0000);
        push(48'h2222_3333_4444);
        got_q.delete();
        en = 1'b1;
        wait_mid_frame("t6");
        chk("t6_mid_data", 64'(tx_data), 64'(16'h0001));
`ifdef OUTFIFO_RD_PARITY_EN
        chk("t6_par_0001", 64'(tx_par), 64'(0));
        if (got_q.size() >= 1) chk("t6_par_0000", 64'(got_q[0].par), 64'(1));
`endif
        rst_n = 1'b0;
        cycle();
        chk("t6_rden",     64'(fifo_rden), 64'(0));
        chk("t6_valid",    64'(tx_valid),  64'(0));
        chk("t6_data",     64'(tx_data),   64'(0));
        chk("t6_first",    64'(tx_first),  64'(0));
        chk("t6_last",     64'(tx_last),   64'(0));
        chk("t6_daq",      64'(tx_daq),    64'(0));
        chk("t6_busy",     64'(busy),      64'(0));
        chk("t6_word_cnt", 64'(word_cnt),  64'(0));
`ifdef OUTFIFO_RD_PARITY_EN
        chk("t6_par", 64'(tx_par), 64'(0));
`endif
        rst_n = 1'b1;
        got_q.delete();
        run(10);
        chk("t6_frames", 64'(got_q.size()), 64'(3));
        if (got_q.size() >= 1) begin
            chk("t6_next_data",  64'(got_q[0].data),  64'(16'h4444));
            chk("t6_next_first", 64'(got_q[0].first), 64'(1));
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
                push_req  = 1'b1;
                push_word = rnd48();
            end
            cycle();
        end
        rst_n    = 1'b1;
        en       = 1'b1;
        flush    = 1'b0;
        tx_ready = 1'b1;
        run(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
